// File: rtl/binocular_pkg.sv
// Shared defaults and types for the line-column buffer and the binary-window stage.
// No logic of its own; zero latency.
// No flow control here; consumers define their own handshake.
package binocular_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int ROWS_DEF  = 7;
  localparam int PIX_W_DEF = 1;

  // One vertical column of the window: slice k holds line y-(ROWS-1)+k.
  typedef logic [ROWS_DEF*PIX_W_DEF-1:0] col_t;

  // Counter width for an extent of n, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One stored image line: simple dual-port RAM, synchronous read.
// Read data appears 1 cycle after rd_en; same-address write returns the old word.
// No backpressure; rd_data holds while rd_en is low.
module line_ram
  import binocular_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 1,
  localparam int AW = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write: the read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/line_column_buffer.sv
// Turns a raster pixel stream into vertical ROWS-high columns using ROWS-1 ring-ordered line RAMs.
// Fixed 1-cycle latency from accepted pixel to registered column.
// No backpressure: in_valid low stalls everything, column/position outputs hold, pulses drop.
module line_column_buffer
  import binocular_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int ROWS  = ROWS_DEF,   // at least 2: the ring needs one line RAM
  parameter int PIX_W = PIX_W_DEF,
  localparam int XW = clog2_min1(IMG_W),
  localparam int YW = clog2_min1(IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [PIX_W-1:0]      in_pix,
  output logic [ROWS*PIX_W-1:0] col_out,
  output logic                  col_valid,
  output logic [XW-1:0]         col_x,
  output logic [YW-1:0]         col_y,
  output logic                  col_sol,
  output logic                  frame_end
);

  localparam int RING = ROWS - 1;
  localparam int SW   = clog2_min1(RING);
  localparam int FW   = clog2_min1(ROWS);

  // Position/fill state of the next pixel to arrive.
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [FW-1:0] fill;
  logic [SW-1:0] wr_slot;

  // Effective state for the pixel being accepted (sof forces a fresh frame).
  logic [XW-1:0] x_e;
  logic [YW-1:0] y_e;
  logic [FW-1:0] fill_e;
  logic [SW-1:0] slot_e;

  // Registered context that goes with the RAM read data.
  logic [PIX_W-1:0] pix_q;
  logic [SW-1:0]    slot_q;
  logic [FW-1:0]    fill_q;
  logic [PIX_W-1:0] rd_data [RING];
  logic [SW:0]      idx;

  // sof overrides the running counters so that pixel is (0,0) with an empty ring.
  always_comb begin
    x_e    = in_sof ? '0 : x;
    y_e    = in_sof ? '0 : y;
    fill_e = in_sof ? '0 : fill;
    slot_e = in_sof ? '0 : wr_slot;
  end

  for (genvar i = 0; i < RING; i++) begin : g_ram
    line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_ram (
      .clk     (clk),
      .rd_en   (in_valid),
      .rd_addr (x_e),
      .rd_data (rd_data[i]),
      .wr_en   (in_valid && (slot_e == SW'(i))),
      .wr_addr (x_e),
      .wr_data (in_pix)
    );
  end

  // Advance x; at line end bump y, rotate the ring slot and grow fill; at frame end restart all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x       <= '0;
      y       <= '0;
      fill    <= '0;
      wr_slot <= '0;
    end else if (in_valid) begin
      if (x_e == XW'(IMG_W - 1)) begin
        x <= '0;
        if (y_e == YW'(IMG_H - 1)) begin
          y       <= '0;
          fill    <= '0;
          wr_slot <= '0;
        end else begin
          y       <= y_e + 1'b1;
          fill    <= (fill_e == FW'(RING)) ? fill_e : fill_e + 1'b1;
          wr_slot <= (slot_e == SW'(RING - 1)) ? '0 : slot_e + 1'b1;
        end
      end else begin
        x       <= x_e + 1'b1;
        y       <= y_e;
        fill    <= fill_e;
        wr_slot <= slot_e;
      end
    end
  end

  // Register per-column qualifiers; frame_end looks at the raw position so a sof on the last pixel still reports it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q     <= '0;
      slot_q    <= '0;
      fill_q    <= '0;
      col_valid <= 1'b0;
      col_sol   <= 1'b0;
      col_x     <= '0;
      col_y     <= '0;
      frame_end <= 1'b0;
    end else if (in_valid) begin
      pix_q     <= in_pix;
      slot_q    <= slot_e;
      fill_q    <= fill_e;
      col_valid <= (fill_e == FW'(RING));
      col_sol   <= (fill_e == FW'(RING)) && (x_e == '0);
      col_x     <= x_e;
      col_y     <= y_e;
      frame_end <= (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));
    end else begin
      col_valid <= 1'b0;
      col_sol   <= 1'b0;
      frame_end <= 1'b0;
    end
  end

  // Oldest line sits in the slot being overwritten; walk the ring upward, blank lines not yet filled.
  always_comb begin
    col_out = '0;
    idx     = '0;
    col_out[RING*PIX_W +: PIX_W] = pix_q;
    for (int k = 0; k < RING; k++) begin
      idx = {1'b0, slot_q} + (SW + 1)'(k);
      if (idx >= (SW + 1)'(RING)) idx = idx - (SW + 1)'(RING);
      if (k + int'(fill_q) >= RING) col_out[k*PIX_W +: PIX_W] = rd_data[idx[SW-1:0]];
    end
  end

endmodule

// File: doc/line_column_buffer.md
Name: line_column_buffer

Overview:
- Upstream feeder of the 7×7 binary-window stage (self-adaption shift window).
- Accepts a raster-order binary pixel stream and stores the previous ROWS-1 lines in circular line memories.
- Each accepted pixel produces one vertical column of ROWS pixels at the same x: the current line plus the ROWS-1 lines above it.
- The downstream stage shifts these columns horizontally to form its window.

Parameters:
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- ROWS, 7, column height (window size).
- PIX_W, 1, bits per pixel.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  pixel qualifier; no advance when low.
- in_sof  input  1  start of frame; qualified by in_valid.
- in_pix  input  PIX_W  pixel data.
- col_out  output  ROWS*PIX_W  column; slice k = line y-(ROWS-1)+k, so the top slice holds the current line.
- col_valid  output  1  column valid; high only once ROWS lines are filled.
- col_x  output  clog2(IMG_W)  x of the column.
- col_y  output  clog2(IMG_H)  y of the current (newest) line.
- col_sol  output  1  column is x=0.
- frame_end  output  1  one-cycle pulse with the column at (IMG_W-1, IMG_H-1).

Behaviour:
- Reset (rst low, async): x, y and fill counters = 0, the write-slot pointer = 0, and all outputs = 0. Line RAM contents are not cleared; the fill mask makes them irrelevant.
- Accept: in_valid=1 on a rising edge.
- Stall: in_valid=0 holds all state. col_valid and frame_end drop to 0 the next cycle; col_out, col_x and col_y hold.
- Latency: fixed 1 cycle, accept -> column registered.
- Memory organisation:
  - ROWS-1 line RAMs, depth IMG_W, in a circular ring indexed by wr_slot.
  - On each accept, all RAMs are read at address x (read-before-write) and in_pix is written to RAM[wr_slot] at x.
  - Column assembly: oldest line = RAM[wr_slot], ascending ring order, current in_pix on top.
- Counters:
  - x increments per accept. At x=IMG_W-1: x->0, y++, wr_slot advances modulo ROWS-1, and fill saturates-increments to ROWS-1.
  - At (IMG_W-1, IMG_H-1): y->0 and frame_end pulses with that column.
- Fill masking:
  - Slice k is forced to 0 unless its line exists: k >= ROWS-1-fill.
  - col_valid = accept & (fill == ROWS-1).
  - fill resets at every frame start, so no data from the previous frame leaks into the new frame.
- in_sof with accept: that pixel is treated as (0,0). This applies at any position, including mid-line or mid-frame (resync), and takes priority over the wrap logic:
  - x=0, y=0, fill=0, wr_slot=0.
  - The pixel is written normally.
  - No column is valid for this pixel unless ROWS=1.
- Short frame: no in_sof at the natural end -> wrap to (0,0) automatically, with fill cleared as for sof.
- Simultaneous wrap and sof: sof wins; frame_end still pulses if the pre-accept position was the last pixel.
- col_sol = col_valid & (col_x==0).
- Widths: counters use clog2 of the extent. Comparisons are against IMG_W-1 and IMG_H-1 exactly; there are no overflow states.

Decomposition:
- Shared package (binocular_pkg): ROWS, IMG_W, IMG_H defaults, PIX_W, and a col_t typedef (ROWS*PIX_W vector) that is also used by the window stage.
- One sub-module: line_ram
  - Simple dual-port, depth IMG_W, width PIX_W, synchronous read, read-before-write at the same address.
  - Instantiated ROWS-1 times via generate.

Test Plan:
- Reset mid-stream: drive 100 pixels, assert rst low for 1 cycle -> all outputs 0 immediately. The next sof frame behaves as a fresh start.
- Fill: IMG_W=8, IMG_H=10. Stream pixel = y[0] ^ x[0] from sof -> col_valid first high at (0,6). Top slice = current pixel; slice 0 = line 0's pixel at the same x. Before line 6, col_valid stays 0.
- Stall: insert in_valid=0 gaps of 1-5 cycles randomly -> the column sequence is identical to the gapless run, and col_valid is never high during a gap.
- Frame end: run a full 8×10 frame -> exactly one frame_end, at (7,9). The next frame restarts fill, and no column is valid until its line 6.
- Mid-frame resync: sof at (3,7) -> that pixel is (0,0), fill=0, and no col_valid until the new frame's line 6. No stale data appears in any column.
- Ring wrap: stream 3 frames with a unique per-line pattern (pixel = line-number bit 0..2 with PIX_W=3) -> every column at y≥6 equals lines y-6..y in order, across multiple wr_slot wrap-arounds.
